// File: rtl/ifu_fetch_pkg.sv
// ============================================================================
//  Module      : ifu_fetch_pkg
//  Description : Shared constants for the instruction fetch unit: FSM state
//                encodings, instruction width and the sequential PC step.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef XLEN
`define XLEN 32
`endif

package ifu_fetch_pkg;

    localparam int                c_INSTR_W = 32;
    localparam logic [`XLEN-1:0]  c_PC_INC  = `XLEN'd4;

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [`XLEN-1:0] align_pc(input logic [`XLEN-1:0] pc);
        return pc & {{(`XLEN-2){1'b1}}, 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/ifu_ibuf.sv
// ============================================================================
//  Module      : ifu_ibuf
//  Description : Synchronous {instr, pc} FIFO with push/pop/flush and a
//                free-entry count; pointers carry an extra wrap bit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifu_ibuf
    import ifu_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_flush,
    input  logic [c_INSTR_W-1:0]   i_instr,
    input  logic [`XLEN-1:0]       i_pc,
    output logic                   o_valid,
    output logic [c_INSTR_W-1:0]   o_instr,
    output logic [`XLEN-1:0]       o_pc,
    output logic [$clog2(DEPTH):0] o_free_cnt
);

    localparam int PW = $clog2(DEPTH) + 1;

    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [c_INSTR_W-1:0] instr_q [DEPTH];
    logic [`XLEN-1:0]     pc_q    [DEPTH];
    logic [PW-1:0]        w_count;
    logic                 w_empty;

    always_comb begin
        w_count    = wr_ptr_q - rd_ptr_q;
        w_empty    = (wr_ptr_q == rd_ptr_q);
        o_free_cnt = PW'(DEPTH) - w_count;
        o_valid    = !w_empty && !rst;
        o_instr    = o_valid ? instr_q[rd_ptr_q[PW-2:0]] : '0;
        o_pc       = o_valid ? pc_q[rd_ptr_q[PW-2:0]]    : '0;

        wr_ptr_d   = wr_ptr_q + PW'(i_push);
        rd_ptr_d   = rd_ptr_q + PW'(i_pop && !w_empty);
        // Flush wins over a same-cycle push or pop.
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !i_flush) begin
            instr_q[wr_ptr_q[PW-2:0]] <= i_instr;
            pc_q[wr_ptr_q[PW-2:0]]    <= i_pc;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ifu_fetch.sv
// ============================================================================
//  Module      : ifu_fetch
//  Description : Fetch stage: owns the PC, issues single-outstanding word
//                fetches, buffers returns and honours execute redirects.
//                Optional IFU_PERF_CNT_EN adds fetch/flush perf counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [`XLEN-1:0] RESET_PC   = `XLEN'h8000_0000,
    parameter int               IBUF_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 imem_req_valid,
    input  logic                 imem_req_ready,
    output logic [`XLEN-1:0]     imem_req_addr,
    input  logic                 imem_rsp_valid,
    input  logic [c_INSTR_W-1:0] imem_rsp_data,
    input  logic                 jump_en,
    input  logic [`XLEN-1:0]     jump_pc,
    input  logic                 halt,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    output logic [c_INSTR_W-1:0] instr,
    output logic [`XLEN-1:0]     data_pc,
    output logic [`XLEN-1:0]     snxt_pc
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [63:0]          perf_fetch_cnt,
    output logic [63:0]          perf_flush_cnt
`endif
);

    localparam int FREE_W = $clog2(IBUF_DEPTH) + 1;

    logic [1:0]       state_q, state_d;
    logic [`XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [`XLEN-1:0] pend_pc_q, pend_pc_d;
    logic             stale_q, stale_d;
    logic             hold_q, hold_d;

    logic [FREE_W-1:0] w_free_cnt;
    logic [`XLEN-1:0]  w_jump_pc;
    logic              w_req_fire;
    logic              w_push;

    always_comb begin
        w_jump_pc      = align_pc(jump_pc);
        // A request already on the bus stays up regardless of halt/occupancy.
        imem_req_valid = (state_q == S_REQ) && !rst
                         && (hold_q || (!halt && (w_free_cnt != '0)));
        imem_req_addr  = fetch_pc_q;
        w_req_fire     = imem_req_valid && imem_req_ready;
        w_push         = (state_q == S_WAIT) && imem_rsp_valid && !jump_en;
        snxt_pc        = instr_valid ? data_pc + c_PC_INC : '0;
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        pend_pc_d  = pend_pc_q;
        stale_d    = stale_q;
        hold_d     = imem_req_valid && !imem_req_ready;
        case (state_q)
            S_REQ: begin
                if (w_req_fire) begin
                    state_d = (stale_q || jump_en) ? S_DROP : S_WAIT;
                    if (jump_en)      fetch_pc_d = w_jump_pc;
                    else if (stale_q) fetch_pc_d = pend_pc_q;
                    else              fetch_pc_d = fetch_pc_q + c_PC_INC;
                end else if (jump_en) begin
                    // Parked request keeps its address; target applies after acceptance.
                    if (imem_req_valid) begin
                        stale_d   = 1'b1;
                        pend_pc_d = w_jump_pc;
                    end else begin
                        fetch_pc_d = w_jump_pc;
                    end
                end
            end
            S_WAIT: begin
                if (jump_en) fetch_pc_d = w_jump_pc;
                if (imem_rsp_valid) state_d = S_REQ;
                else if (jump_en)   state_d = S_DROP;
            end
            S_DROP: begin
                if (jump_en) fetch_pc_d = w_jump_pc;
                if (imem_rsp_valid) begin
                    state_d = S_REQ;
                    stale_d = 1'b0;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_REQ;
            fetch_pc_q <= RESET_PC;
            pend_pc_q  <= RESET_PC;
            stale_q    <= 1'b0;
            hold_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pend_pc_q  <= pend_pc_d;
            stale_q    <= stale_d;
            hold_q     <= hold_d;
        end
    end

    // In S_WAIT fetch_pc already points one word past the outstanding request.
    ifu_ibuf #(
        .DEPTH (IBUF_DEPTH)
    ) u_ibuf (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_pop      (instr_valid && instr_ready),
        .i_flush    (jump_en),
        .i_instr    (imem_rsp_data),
        .i_pc       (fetch_pc_q - c_PC_INC),
        .o_valid    (instr_valid),
        .o_instr    (instr),
        .o_pc       (data_pc),
        .o_free_cnt (w_free_cnt)
    );

`ifdef IFU_PERF_CNT_EN
    logic [63:0] perf_fetch_q, perf_fetch_d;
    logic [63:0] perf_flush_q, perf_flush_d;
    logic        w_rsp_drop;

    always_comb begin
        w_rsp_drop     = imem_rsp_valid
                         && ((state_q == S_DROP) || ((state_q == S_WAIT) && jump_en));
        perf_fetch_d   = perf_fetch_q + 64'(instr_valid && instr_ready);
        perf_flush_d   = perf_flush_q + 64'(jump_en) + 64'(w_rsp_drop);
        perf_fetch_cnt = perf_fetch_q;
        perf_flush_cnt = perf_flush_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_flush_q <= perf_flush_d;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_ifu_fetch.sv
// ============================================================================
//  Module      : tb_ifu_fetch
//  Description : Directed cycle table plus randomized bus/redirect traffic
//                checked against an architectural instruction-stream model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ifu_fetch;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam int          DEPTH  = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             imem_req_valid;
    logic             imem_req_ready;
    logic [`XLEN-1:0] imem_req_addr;
    logic             imem_rsp_valid;
    logic [31:0]      imem_rsp_data;
    logic             jump_en;
    logic [`XLEN-1:0] jump_pc;
    logic             halt;
    logic             instr_valid;
    logic             instr_ready;
    logic [31:0]      instr;
    logic [`XLEN-1:0] data_pc;
    logic [`XLEN-1:0] snxt_pc;
`ifdef IFU_PERF_CNT_EN
    logic [63:0]      perf_fetch_cnt;
    logic [63:0]      perf_flush_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ifu_fetch #(
        .RESET_PC   (RST_PC),
        .IBUF_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .jump_en        (jump_en),
        .jump_pc        (jump_pc),
        .halt           (halt),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .data_pc        (data_pc),
        .snxt_pc        (snxt_pc)
`ifdef IFU_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    typedef struct {
        logic        rst, rdy, rv;
        logic [31:0] rdata;
        logic        jen;
        logic [31:0] jpc;
        logic        hlt, ir;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_pc, e_snxt, e_instr;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic rdy, input logic rv,
                                input logic [31:0] rd, input logic jen, input logic [31:0] jpc,
                                input logic hlt, input logic ir, input logic e_rv,
                                input logic [31:0] e_addr, input logic e_iv,
                                input logic [31:0] e_pc, input logic [31:0] e_snxt,
                                input logic [31:0] e_instr);
        vec_t v;
        v.rst = r; v.rdy = rdy; v.rv = rv; v.rdata = rd; v.jen = jen; v.jpc = jpc;
        v.hlt = hlt; v.ir = ir; v.e_rv = e_rv; v.e_addr = e_addr; v.e_iv = e_iv;
        v.e_pc = e_pc; v.e_snxt = e_snxt; v.e_instr = e_instr;
        return v;
    endfunction

    // Contents of the fetch memory as seen by the randomized bus.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    vec_t tbl[30];

    // Randomized-phase state
    logic        bus_busy, was_busy, prev_hold, consume;
    int          bus_lat;
    logic [31:0] bus_addr, exp_pc, prev_addr;
    int          consumed;

    initial begin
        rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        jump_en = 1'b0; jump_pc = '0; halt = 1'b0; instr_ready = 1'b0;

        //          rst rdy rv rdata         jen jpc           hlt ir | rv addr          iv pc            snxt          instr
        tbl[0]  = mk(1, 0, 0, 32'h0,        0, 32'h0,        0, 0,   0, 32'h8000_0000, 0, 32'h0,        32'h0,        32'h0);
        tbl[1]  = mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 0,   1, 32'h8000_0000, 0, 32'h0,        32'h0,        32'h0);
        tbl[2]  = mk(0, 1, 1, 32'h13,       0, 32'h0,        0, 0,   0, 32'h8000_0004, 0, 32'h0,        32'h0,        32'h0);
        tbl[3]  = mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 0,   1, 32'h8000_0004, 1, 32'h8000_0000, 32'h8000_0004, 32'h13);
        tbl[4]  = mk(0, 0, 1, 32'h0010_0093, 0, 32'h0,       0, 0,   0, 32'h8000_0008, 1, 32'h8000_0000, 32'h8000_0004, 32'h13);
        tbl[5]  = mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 0,   0, 32'h8000_0008, 1, 32'h8000_0000, 32'h8000_0004, 32'h13);
        tbl[6]  = mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 1,   0, 32'h8000_0008, 1, 32'h8000_0000, 32'h8000_0004, 32'h13);
        tbl[7]  = mk(0, 1, 0, 32'h0,        0, 32'h0,        1, 0,   0, 32'h8000_0008, 1, 32'h8000_0004, 32'h8000_0008, 32'h0010_0093);
        tbl[8]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 0,   1, 32'h8000_0008, 1, 32'h8000_0004, 32'h8000_0008, 32'h0010_0093);
        tbl[9]  = mk(0, 0, 0, 32'h0,        1, 32'h8000_0203, 1, 1,  1, 32'h8000_0008, 1, 32'h8000_0004, 32'h8000_0008, 32'h0010_0093);
        tbl[10] = mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 0,   1, 32'h8000_0008, 0, 32'h0,        32'h0,        32'h0);
        tbl[11] = mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 0,   1, 32'h8000_0008, 0, 32'h0,        32'h0,        32'h0);
        tbl[12] = mk(0, 0, 1, 32'hDEAD_BEEF, 0, 32'h0,       0, 0,   0, 32'h8000_0200, 0, 32'h0,        32'h0,        32'h0);
        tbl[13] = mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 0,   1, 32'h8000_0200, 0, 32'h0,        32'h0,        32'h0);
        tbl[14] = mk(0, 0, 1, 32'h11,       0, 32'h0,        0, 0,   0, 32'h8000_0204, 0, 32'h0,        32'h0,        32'h0);
        tbl[15] = mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 0,   1, 32'h8000_0204, 1, 32'h8000_0200, 32'h8000_0204, 32'h11);
        tbl[16] = mk(0, 1, 0, 32'h0,        1, 32'h8000_0100, 0, 1,  1, 32'h8000_0204, 1, 32'h8000_0200, 32'h8000_0204, 32'h11);
        tbl[17] = mk(0, 0, 1, 32'h22,       0, 32'h0,        0, 0,   0, 32'h8000_0100, 0, 32'h0,        32'h0,        32'h0);
        tbl[18] = mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 0,   1, 32'h8000_0100, 0, 32'h0,        32'h0,        32'h0);
        tbl[19] = mk(1, 0, 0, 32'h0,        0, 32'h0,        0, 0,   0, 32'h8000_0100, 0, 32'h0,        32'h0,        32'h0);
        tbl[20] = mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 0,   1, 32'h8000_0000, 0, 32'h0,        32'h0,        32'h0);
        tbl[21] = mk(0, 0, 1, 32'h33,       0, 32'h0,        0, 0,   0, 32'h8000_0004, 0, 32'h0,        32'h0,        32'h0);
        tbl[22] = mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 0,   1, 32'h8000_0004, 1, 32'h8000_0000, 32'h8000_0004, 32'h33);
        tbl[23] = mk(0, 0, 0, 32'h0,        1, 32'h8000_0100, 0, 1,  0, 32'h8000_0008, 1, 32'h8000_0000, 32'h8000_0004, 32'h33);
        tbl[24] = mk(0, 0, 1, 32'h44,       0, 32'h0,        0, 0,   0, 32'h8000_0100, 0, 32'h0,        32'h0,        32'h0);
        tbl[25] = mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 0,   1, 32'h8000_0100, 0, 32'h0,        32'h0,        32'h0);
        tbl[26] = mk(0, 0, 1, 32'h55,       0, 32'h0,        0, 0,   0, 32'h8000_0104, 0, 32'h0,        32'h0,        32'h0);
        tbl[27] = mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 0,   1, 32'h8000_0104, 1, 32'h8000_0100, 32'h8000_0104, 32'h55);
        tbl[28] = mk(1, 0, 0, 32'h0,        0, 32'h0,        0, 0,   0, 32'h8000_0108, 0, 32'h0,        32'h0,        32'h0);
        tbl[29] = mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 0,   1, 32'h8000_0000, 0, 32'h0,        32'h0,        32'h0);

        repeat (2) @(negedge clk);

        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            rst = tbl[i].rst; imem_req_ready = tbl[i].rdy; imem_rsp_valid = tbl[i].rv;
            imem_rsp_data = tbl[i].rdata; jump_en = tbl[i].jen; jump_pc = tbl[i].jpc;
            halt = tbl[i].hlt; instr_ready = tbl[i].ir;
            #1;
            chk($sformatf("row%0d req_valid", i), 64'(imem_req_valid), 64'(tbl[i].e_rv));
            chk($sformatf("row%0d req_addr", i),  64'(imem_req_addr),  64'(tbl[i].e_addr));
            chk($sformatf("row%0d instr_valid", i), 64'(instr_valid),  64'(tbl[i].e_iv));
            chk($sformatf("row%0d data_pc", i),   64'(data_pc),        64'(tbl[i].e_pc));
            chk($sformatf("row%0d snxt_pc", i),   64'(snxt_pc),        64'(tbl[i].e_snxt));
            chk($sformatf("row%0d instr", i),     64'(instr),          64'(tbl[i].e_instr));
        end

        // Randomized traffic against the architectural stream model.
        bus_busy = 1'b0; bus_lat = 0; bus_addr = '0; prev_hold = 1'b0; prev_addr = '0;
        exp_pc = RST_PC; consumed = 0;
        @(negedge clk);
        rst = 1'b1; imem_rsp_valid = 1'b0; jump_en = 1'b0; halt = 1'b0;
        instr_ready = 1'b0; imem_req_ready = 1'b0;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (cyc == 2000) begin
                // Reset mid-stream; the bus abandons whatever was outstanding.
                rst = 1'b1; imem_rsp_valid = 1'b0; jump_en = 1'b0; instr_ready = 1'b0;
                bus_busy = 1'b0; prev_hold = 1'b0; exp_pc = RST_PC;
                continue;
            end
            rst = 1'b0;
            was_busy = bus_busy;
            imem_rsp_valid = bus_busy && (bus_lat == 0);
            imem_rsp_data  = imem_rsp_valid ? mem(bus_addr) : $urandom;
            if (bus_busy) begin
                if (bus_lat == 0) bus_busy = 1'b0;
                else              bus_lat--;
            end
            imem_req_ready = ($urandom_range(3) != 0);
            halt           = ((cyc % 250) >= 220) || ($urandom_range(15) == 0);
            instr_ready    = ($urandom_range(2) != 0);
            consume        = instr_valid && instr_ready;
            jump_en        = consume && ($urandom_range(7) == 0);
            jump_pc        = {RST_PC[31:12], 12'($urandom)};
            #1;
            if (was_busy)
                chk("single_outstanding", 64'(imem_req_valid), 64'd0);
            if (prev_hold) begin
                chk("held_valid", 64'(imem_req_valid), 64'd1);
                chk("held_addr",  64'(imem_req_addr),  64'(prev_addr));
            end else if (halt) begin
                chk("halt_blocks_req", 64'(imem_req_valid), 64'd0);
            end
            if (imem_req_valid)
                chk("addr_aligned", 64'(imem_req_addr[1:0]), 64'd0);
            if (consume) begin
                chk("stream_pc",    64'(data_pc), 64'(exp_pc));
                chk("stream_instr", 64'(instr),   64'(mem(exp_pc)));
                chk("stream_snxt",  64'(snxt_pc), 64'(exp_pc + 32'd4));
                exp_pc = jump_en ? {jump_pc[31:2], 2'b00} : exp_pc + 32'd4;
                consumed++;
            end
            if (imem_req_valid && imem_req_ready) begin
                bus_busy = 1'b1;
                bus_lat  = $urandom_range(2);
                bus_addr = imem_req_addr;
            end
            prev_hold = imem_req_valid && !imem_req_ready;
            prev_addr = imem_req_addr;
        end
        chk("stream_progress", 64'(consumed > 300), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch stage directly upstream of the execute stage.
- Owns the architectural PC and issues word fetches on a valid/ready instruction bus.
- Buffers returned instructions in a small FIFO and presents them with their PC and static next PC (pc+4) to decode/execute.
- Accepts redirects (jump_en/jump_pc) from execute, flushing buffered and in-flight fetches.

Parameters:
RESET_PC, `XLEN'h8000_0000, PC value loaded on reset
IBUF_DEPTH, 2, instruction FIFO entries (power of 2, >=2)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  bus accepts request
imem_req_addr  output  `XLEN  fetch address, 4-byte aligned
imem_rsp_valid  input  1  response data valid (always accepted)
imem_rsp_data  input  32  fetched instruction word
jump_en  input  1  redirect from execute
jump_pc  input  `XLEN  redirect target
halt  input  1  stop issuing new requests (ebreak)
instr_valid  output  1  IBUF head valid
instr_ready  input  1  downstream consumes head
instr  output  32  head instruction
data_pc  output  `XLEN  head PC
snxt_pc  output  `XLEN  head PC + 4

Behaviour:
- Reset (one clock cycle, synchronous):
  - fetch_pc=RESET_PC; state=S_REQ; IBUF empty; stale=0.
  - Outputs: imem_req_valid=0 during the reset cycle, instr_valid=0, instr/data_pc/snxt_pc=0.
  - Reset mid-transaction discards any outstanding response; the bus side must tolerate this.
- At most one outstanding request.
- imem_req_addr = fetch_pc.
- FSM states:
  - S_REQ: imem_req_valid = !halt && (IBUF free entries > 0). Once asserted, valid and addr are held stable until imem_req_ready. On handshake: fetch_pc+=4, go to S_WAIT (or S_DROP if stale is set or jump_en is asserted that cycle).
  - S_WAIT: on imem_rsp_valid, push {data, pc} into IBUF, go to S_REQ. Space is guaranteed by the issue rule.
  - S_DROP: on imem_rsp_valid, discard the response, clear stale, go to S_REQ.
- IBUF free-entry accounting counts the in-flight request as occupied.
- Redirect, when jump_en=1 (execute asserts it only for the instruction it consumes, i.e. together with instr_valid&instr_ready):
  - IBUF flushed next cycle; fetch_pc <= {jump_pc[`XLEN-1:2],2'b00}.
  - If in S_WAIT (or a response arrives the same cycle), the response is dropped: go to S_DROP unless the response arrives that cycle.
  - If in S_REQ with an unaccepted request pending, the request stays unchanged, stale=1, and fetch_pc updates only after acceptance (hold redirect target in a pending register).
  - A redirect has priority over the same-cycle push/pop.
- IBUF:
  - Circular pointers with wrap-around; full/empty via an extra pointer bit.
  - Simultaneous push and pop when full is not possible; when empty, no bypass (1-cycle fetch-to-issue minimum).
- Latency: request handshake at cycle N, response at N+k, instr_valid at N+k+1.
- halt blocks only new requests; an outstanding response still completes; IBUF keeps draining.
- snxt_pc = data_pc + 4, `XLEN-bit wrap.

Optional Feature:
- Macro: IFU_PERF_CNT_EN.
- Defined: adds output ports perf_fetch_cnt (64) and perf_flush_cnt (64), both reset to 0.
  - perf_fetch_cnt increments on each IBUF pop.
  - perf_flush_cnt increments on each jump_en cycle, plus once per dropped response.
  - Both wrap at 2^64.
- Undefined: the ports and counters are absent; no other change.

Decomposition:
- Shared package: the state encodings S_REQ/S_WAIT/S_DROP, the instruction width constant 32, and the PC increment constant 4, alongside the existing `XLEN macro in default.v.
- One sub-module, ifu_ibuf: a synchronous FIFO of {instr, pc}, depth IBUF_DEPTH, with push/pop/flush and a free_cnt output.

Test Plan:
1. Reset, then a bus with 1-cycle ready and a 1-cycle response returning 0x00000013 -> addresses 0x80000000, 0x80000004, ... issued; instr_valid rises with data_pc=0x80000000 and snxt_pc=0x80000004.
2. instr_ready=0 for 10 cycles -> at most IBUF_DEPTH entries are held; no request is issued while full; no loss or reorder after release.
3. jump_en with jump_pc=0x80000100 while in S_WAIT -> next response dropped; next request address is 0x80000100; the old PC is never presented.
4. imem_req_ready=0 for 3 cycles, with jump_en on cycle 1 to 0x80000200 -> imem_req_addr held stable until the handshake; that response is dropped; next request is 0x80000200.
5. halt=1 with one request outstanding -> the response is buffered; no new request while halted; resumes at the next sequential PC after halt=0.
6. rst asserted in S_WAIT -> next cycle IBUF empty; the next request after reset goes to RESET_PC.
